// File: rtl/sms_pow_seq.sv
// sms_pow_seq: sequential power-map S-box engine, y = x^E over GF(2^6).
// Left-to-right square-and-multiply over the 6 exponent bits using a single
// shared GF(2^6) multiplier (modulus t^6 + t + 1, polynomial basis).
// One operation in flight; valid/ready on both sides.
//
// Parameters:
//   E          exponent, legal 1..62
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand valid
//   in_ready   operand accepted (high only in IDLE)
//   x          operand, 6-bit polynomial basis
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   y          result x^E, zero outside DONE
//   busy       high in every state except IDLE
//
// Build option:
//   SMS_POW_ZERO_BYPASS_EN  accepting x==0 jumps straight to DONE with y=0.

module sms_pow_seq #(
   parameter int unsigned E = 40
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [5:0] x,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [5:0] y,
   output logic       busy
);

   localparam int unsigned W  = 6;
   localparam int unsigned IW = 3;

   // Exponent bits scanned MSB first; t^6 reduces to t + 1.
   localparam logic [W-1:0]  EXP     = W'(E);
   localparam logic [W-1:0]  MOD_LO  = 6'b000011;
   localparam logic [IW-1:0] IDX_TOP = IW'(W - 1);

   if (E < 1 || E > 62) begin : g_bad_e
      $error("sms_pow_seq: exponent E must lie in 1..62");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SQR  = 2'd1,
      MUL  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t         state,     state_nxt;
   logic [W-1:0]   xr,        xr_nxt;
   logic [W-1:0]   acc,       acc_nxt;
   logic [IW-1:0]  idx,       idx_nxt;
   logic           in_ready_nxt;
   logic           out_valid_nxt;
   logic           busy_nxt;
   logic [W-1:0]   y_nxt;

   logic [W-1:0]   mul_a;
   logic [W-1:0]   mul_b;
   logic [W-1:0]   mul_p;

   // Operand mux for the single multiplier: (acc, acc) squares, (acc, xr) multiplies.
   always_comb begin
      mul_a = acc;
      mul_b = (state == MUL) ? xr : acc;
   end

   // GF(2^6) multiply, Horner form from the MSB of mul_b: p = p*t + b_i*a.
   always_comb begin
      mul_p = '0;
      for (int i = W - 1; i >= 0; i--) begin
         mul_p = {mul_p[W-2:0], 1'b0} ^ (mul_p[W-1] ? MOD_LO : {W{1'b0}});
         if (mul_b[i]) begin
            mul_p = mul_p ^ mul_a;
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         xr        <= '0;
         acc       <= '0;
         idx       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         y         <= '0;
      end else begin
         state     <= state_nxt;
         xr        <= xr_nxt;
         acc       <= acc_nxt;
         idx       <= idx_nxt;
         in_ready  <= in_ready_nxt;
         out_valid <= out_valid_nxt;
         busy      <= busy_nxt;
         y         <= y_nxt;
      end
   end

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_nxt = state;
      xr_nxt    = xr;
      acc_nxt   = acc;
      idx_nxt   = idx;

      case (state)
         IDLE: begin
            if (in_valid) begin
               xr_nxt = x;
`ifdef SMS_POW_ZERO_BYPASS_EN
               if (x == '0) begin
                  acc_nxt   = '0;
                  state_nxt = DONE;
               end else begin
                  acc_nxt   = W'(1);
                  idx_nxt   = IDX_TOP;
                  state_nxt = SQR;
               end
`else
               acc_nxt   = W'(1);
               idx_nxt   = IDX_TOP;
               state_nxt = SQR;
`endif
            end
         end
         SQR: begin
            acc_nxt = mul_p;
            // A set exponent bit defers the index step to the following MUL.
            if (EXP[idx]) begin
               state_nxt = MUL;
            end else if (idx == '0) begin
               state_nxt = DONE;
            end else begin
               idx_nxt = idx - IW'(1);
            end
         end
         MUL: begin
            acc_nxt = mul_p;
            if (idx == '0) begin
               state_nxt = DONE;
            end else begin
               idx_nxt   = idx - IW'(1);
               state_nxt = SQR;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Outputs follow the state being entered so they are pure flops.
      in_ready_nxt  = (state_nxt == IDLE);
      out_valid_nxt = (state_nxt == DONE);
      busy_nxt      = (state_nxt != IDLE);
      y_nxt         = (state_nxt == DONE) ? acc_nxt : {W{1'b0}};
   end

endmodule

// File: tb/tb_sms_pow_seq.sv
module tb_sms_pow_seq;

   logic       clk;
   logic       rst;

   logic       in_valid;
   logic       in_ready;
   logic [5:0] x;
   logic       out_valid;
   logic       out_ready;
   logic [5:0] y;
   logic       busy;

   logic       v1, rdy1, ov1, or1, busy1;
   logic [5:0] x1, y1;
   logic       v62, rdy62, ov62, or62, busy62;
   logic [5:0] x62, y62;

   int total;
   int bad;

   sms_pow_seq #(.E(40)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .x(x),
      .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy)
   );

   sms_pow_seq #(.E(1)) dut_e1 (
      .clk(clk), .rst(rst),
      .in_valid(v1), .in_ready(rdy1), .x(x1),
      .out_valid(ov1), .out_ready(or1), .y(y1), .busy(busy1)
   );

   sms_pow_seq #(.E(62)) dut_e62 (
      .clk(clk), .rst(rst),
      .in_valid(v62), .in_ready(rdy62), .x(x62),
      .out_valid(ov62), .out_ready(or62), .y(y62), .busy(busy62)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish want finish before time limit");
      $fatal(1, "watchdog");
   end

   // Reference field arithmetic: schoolbook product, then long division by t^6+t+1.
   function automatic logic [5:0] gmul(input logic [5:0] a, input logic [5:0] b);
      logic [10:0] p;
      logic [10:0] m;
      p = '0;
      for (int i = 0; i < 6; i++)
         if (b[i]) p = p ^ (11'(a) << i);
      for (int k = 10; k >= 6; k--) begin
         m = 11'b000_0100_0011 << (k - 6);
         if (p[k]) p = p ^ m;
      end
      return p[5:0];
   endfunction

   // x^e by e repeated multiplications.
   function automatic logic [5:0] gpow(input logic [5:0] a, input int e);
      logic [5:0] r;
      r = 6'h01;
      for (int k = 0; k < e; k++) r = gmul(r, a);
      return r;
   endfunction

   function automatic int exp_lat(input logic [5:0] xv, input int e);
`ifdef SMS_POW_ZERO_BYPASS_EN
      if (xv == 6'h00) return 1;
`endif
      return 6 + $countones(e);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   // One operation on the E=40 engine; hold = cycles out_ready stays low after out_valid.
   task automatic run_op(input logic [5:0] xv, input int hold,
                         output logic [5:0] yv, output int lat);
      chk("in_ready_before_accept", int'(in_ready), 1);
      in_valid = 1'b1;
      x        = xv;
      @(posedge clk); #1;
      in_valid = 1'b0;
      x        = 6'($urandom);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      yv = y;
      chk("in_ready_low_in_done", int'(in_ready), 0);
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         x        = 6'($urandom);
         @(posedge clk); #1;
         chk("hold_y_stable", int'(y), int'(yv));
         chk("hold_out_valid", int'(out_valid), 1);
         chk("hold_in_ready", int'(in_ready), 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("idle_in_ready", int'(in_ready), 1);
      chk("idle_out_valid", int'(out_valid), 0);
      chk("idle_busy", int'(busy), 0);
      chk("idle_y_zero", int'(y), 0);
   endtask

   typedef struct {
      logic [5:0] xv;
      int         hold;
      logic [5:0] ey;
   } vec_t;

   initial begin
      vec_t       tbl [6];
      logic [5:0] yv;
      int         lat;
      int         seen;
      logic [5:0] rx;
      int         rh;

      total = 0;
      bad   = 0;
      rst   = 1'b1;
      in_valid = 1'b0; x = '0; out_ready = 1'b0;
      v1 = 1'b0;  x1 = '0;  or1 = 1'b1;
      v62 = 1'b0; x62 = '0; or62 = 1'b1;

      tbl[0] = '{xv: 6'h02, hold: 0, ey: 6'h2F};
      tbl[1] = '{xv: 6'h01, hold: 0, ey: 6'h01};
      tbl[2] = '{xv: 6'h00, hold: 0, ey: 6'h00};
      tbl[3] = '{xv: 6'h02, hold: 5, ey: 6'h2F};
      tbl[4] = '{xv: 6'h00, hold: 2, ey: 6'h00};
      tbl[5] = '{xv: 6'h3F, hold: 1, ey: gpow(6'h3F, 40)};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_y", int'(y), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed table
      for (int i = 0; i < 6; i++) begin
         run_op(tbl[i].xv, tbl[i].hold, yv, lat);
         chk($sformatf("tbl%0d_y", i), int'(yv), int'(tbl[i].ey));
         chk($sformatf("tbl%0d_lat", i), lat, exp_lat(tbl[i].xv, 40));
      end

      // Ignored in_valid during backpressure must not start a new operation.
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (busy || out_valid) seen++;
      end
      chk("no_op_after_ignored_valid", seen, 0);

      // Full sweep, back-to-back
      for (int v = 0; v < 64; v++) begin
         run_op(6'(v), 0, yv, lat);
         chk($sformatf("sweep_y_%0h", v), int'(yv), int'(gpow(6'(v), 40)));
         chk($sformatf("sweep_lat_%0h", v), lat, exp_lat(6'(v), 40));
      end

      // Random operands and backpressure
      for (int n = 0; n < 24; n++) begin
         rx = 6'($urandom_range(0, 63));
         rh = $urandom_range(0, 3);
         run_op(rx, rh, yv, lat);
         chk($sformatf("rand_y_%0h", rx), int'(yv), int'(gpow(rx, 40)));
         chk($sformatf("rand_lat_%0h", rx), lat, exp_lat(rx, 40));
      end

      // Reset mid-operation
      in_valid = 1'b1;
      x        = 6'h02;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_busy_before", int'(busy), 1);
      rst = 1'b1;
      #1;
      chk("midrst_in_ready", int'(in_ready), 1);
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_y", int'(y), 0);
      #1;
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("midrst_no_result", seen, 0);
      run_op(6'h03, 0, yv, lat);
      chk("post_rst_y", int'(yv), int'(gpow(6'h03, 40)));
      chk("post_rst_lat", lat, exp_lat(6'h03, 40));

      // E=1 engine
      v1 = 1'b1; x1 = 6'h15;
      @(posedge clk); #1;
      v1 = 1'b0; x1 = 6'h00;
      lat = 0;
      while (!ov1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("e1_y", int'(y1), 6'h15);
      chk("e1_lat", lat, 7);
      @(posedge clk); #1;
      chk("e1_idle", int'(rdy1), 1);

      // E=62 engine: inverse of 0x02
      v62 = 1'b1; x62 = 6'h02;
      @(posedge clk); #1;
      v62 = 1'b0; x62 = 6'h3F;
      lat = 0;
      while (!ov62 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("e62_y", int'(y62), 6'h21);
      chk("e62_lat", lat, exp_lat(6'h02, 62));
      chk("e62_inverse", int'(gmul(y62, 6'h02)), 1);
      @(posedge clk); #1;
      chk("e62_idle", int'(rdy62), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
